// File: rtl/eth_tx_framer_if.sv
// ---------------------------------------------------------------------------
// eth_tx_framer_if
// Payload byte stream from the application into the Ethernet TX framer.
//   s_data  [7:0]  payload byte
//   s_valid        s_data valid; held high while IDLE it requests a frame
//   s_last         final payload byte of the frame (qualified by s_valid)
//   s_ready        byte accepted on a cycle with s_valid && s_ready
// Modports: master = application (byte source), slave = framer.
// ---------------------------------------------------------------------------
interface eth_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/eth_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_framer
// Builds a complete Ethernet frame from an application byte stream and drives
// RMII TXEN/TXD one dibit per clk: preamble, SFD, DST_MAC, SRC_MAC, EtherType,
// payload, zero pad to MIN_PAYLOAD bytes, CRC-32 FCS, then an inter-frame gap.
// Every byte goes out LSB dibit first; multi-byte fields MSB byte first.
//
// Ports:
//   clk     RMII 50 MHz reference clock
//   rst     synchronous, active-high reset
//   src     payload stream (eth_tx_framer_if.slave: s_data/s_valid/s_last/s_ready)
//   txen    RMII transmit enable (registered)
//   txd     RMII transmit dibit (registered, 0 whenever txen is low)
//   busy    high in every state except IDLE
//   tx_err  one-cycle pulse on underrun or oversize abort, coincident with
//           txen dropping
//
// Build option: define ETH_TX_FCS_EN to generate and append the FCS. Without
// it the frame ends after the last payload/pad dibit (external FCS appender).
// ---------------------------------------------------------------------------
module eth_tx_framer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h69695A065491,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG_DIBITS  = 48     // 2..65
) (
    input  logic           clk,
    input  logic           rst,
    eth_tx_framer_if.slave src,
    output logic           txen,
    output logic [1:0]     txd,
    output logic           busy,
    output logic           tx_err
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG} state_t;

    localparam logic [111:0] HDR     = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  MIN_CNT = 11'(MIN_PAYLOAD);
    localparam logic [10:0]  MAX_CNT = 11'(MAX_PAYLOAD);
    // The single IDLE cycle before a new preamble is itself a gap cycle, so
    // the IFG state covers one dibit less to keep the txen-low gap exact.
    localparam logic [5:0]   IFG_LAST = 6'(IFG_DIBITS - 2);
`ifdef ETH_TX_FCS_EN
    localparam state_t DATA_NEXT = FCS;
`else
    localparam state_t DATA_NEXT = IFG;
`endif

    function automatic logic [1:0] byte_dibit(input logic [7:0] b, input logic [1:0] sel);
        case (sel)
            2'd0:    return b[1:0];
            2'd1:    return b[3:2];
            2'd2:    return b[5:4];
            default: return b[7:6];
        endcase
    endfunction

`ifdef ETH_TX_FCS_EN
    // Reflected CRC-32, two bits per call, txd[0] is the earlier bit on the wire.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [31:0] crc_q, crc_d;
`endif

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;        // dibit index within the current state/byte
    logic [7:0]  byte_q, byte_d;      // payload byte being serialised
    logic        last_q, last_d;      // byte_q carried s_last
    logic [10:0] bcnt_q, bcnt_d;      // payload bytes accepted, then padded
    logic        txen_q, txen_d;
    logic [1:0]  txd_q, txd_d;
    logic        err_q, err_d;
    logic        ready;
    logic [6:0]  hdr_lsb;

    // Output registers hold the dibit on the wire for (state_q, cnt_q), so the
    // dibit is derived from the next-state values computed below.
    always_comb begin
        ready = ((state_q == HEADER) && (cnt_q == 6'd55)) ||
                ((state_q == PAYLOAD) && (cnt_q == 6'd3) && !last_q && (bcnt_q != MAX_CNT));

        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                last_d = 1'b0;
                if (src.s_valid) begin
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                end
            end
            PREAMBLE: begin
                if (cnt_q == 6'd31) begin
                    state_d = HEADER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            HEADER, PAYLOAD: begin
                if ((state_q == HEADER) ? (cnt_q != 6'd55) : (cnt_q != 6'd3)) begin
                    cnt_d = cnt_q + 6'd1;
                end else if (state_q == PAYLOAD && last_q) begin
                    cnt_d   = '0;
                    state_d = (bcnt_q < MIN_CNT) ? PAD : DATA_NEXT;
                end else if (ready && src.s_valid) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                    byte_d  = src.s_data;
                    last_d  = src.s_last;
                    bcnt_d  = bcnt_q + 11'd1;
                end else begin
                    // Underrun (ready without valid) or oversize (MAX bytes, no s_last).
                    state_d = IFG;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            PAD: begin
                if (cnt_q != 6'd3) begin
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    cnt_d  = '0;
                    bcnt_d = bcnt_q + 11'd1;
                    if (bcnt_q + 11'd1 == MIN_CNT) state_d = DATA_NEXT;
                end
            end
            FCS: begin
                if (cnt_q == 6'd15) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        txen_d  = state_d inside {PREAMBLE, HEADER, PAYLOAD, PAD, FCS};
        hdr_lsb = {4'd13 - cnt_d[5:2], 3'b000};
        txd_d   = 2'b00;
        case (state_d)
            PREAMBLE: txd_d = (cnt_d == 6'd31) ? 2'b11 : 2'b01;
            HEADER:   txd_d = byte_dibit(HDR[hdr_lsb +: 8], cnt_d[1:0]);
            PAYLOAD:  txd_d = byte_dibit(byte_d, cnt_d[1:0]);
`ifdef ETH_TX_FCS_EN
            FCS:      txd_d = ~crc_q[{cnt_d[3:0], 1'b0} +: 2];
`endif
            default:  txd_d = 2'b00;
        endcase

`ifdef ETH_TX_FCS_EN
        // crc_q is frozen once the last pad/payload dibit is folded in.
        crc_d = crc_q;
        if (state_d == PREAMBLE) begin
            crc_d = '1;
        end else if (state_d inside {HEADER, PAYLOAD, PAD}) begin
            crc_d = crc_dibit(crc_q, txd_d);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            bcnt_q  <= '0;
            txen_q  <= 1'b0;
            txd_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        byte_q <= byte_d;
`ifdef ETH_TX_FCS_EN
        crc_q  <= crc_d;
`endif
    end

    assign src.s_ready = ready;
    assign txen        = txen_q;
    assign txd         = txd_q;
    assign busy        = (state_q != IDLE);
    assign tx_err      = err_q;
endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Transmit-side counterpart of the receive path's MAC filtering.
- Accepts a payload byte stream from the application and drives RMII TXEN/TXD[1:0] at one dibit per clk (50 MHz reference clock domain).
- Builds the complete frame in this order: preamble, SFD, destination MAC, source MAC, EtherType, payload, zero pad to 46 bytes, CRC-32 FCS.
- Enforces inter-frame gap between frames.

Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF, destination address; bits [47:40] transmitted first.
- SRC_MAC, 48'h69695A065491, FPGA source address; bits [47:40] transmitted first.
- ETHERTYPE, 16'h88B5, EtherType field; bits [15:8] transmitted first.
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded.
- MAX_PAYLOAD, 1500, maximum payload bytes accepted per frame.
- IFG_DIBITS, 48, idle cycles with txen low between frames (12 byte times).

Ports:
- clk  in  1  RMII reference clock
- rst  in  1  synchronous, active-high reset
- s_data  in  8  payload byte
- s_valid  in  1  s_data valid; holding it high in IDLE requests a frame
- s_last  in  1  marks final payload byte; qualified by s_valid
- s_ready  out  1  byte accepted on the cycle where s_valid && s_ready
- txen  out  1  RMII transmit enable
- txd  out  2  RMII transmit dibit
- busy  out  1  high in every state except IDLE
- tx_err  out  1  one-cycle pulse on underrun or oversize abort

Behaviour:
- Reset: all outputs 0, state IDLE, IFG counter treated as expired. rst mid-frame drops txen the next cycle with no FCS sent.
- Bit order: every byte is sent LSB dibit first (txd = byte[1:0], [3:2], [5:4], [7:6]). Multi-byte fields are sent most significant byte first.
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG.
- IDLE: s_ready=0. When s_valid=1, go to PREAMBLE; txen rises on the next cycle.
- PREAMBLE: 32 cycles.
  - 28 dibits of 2'b01 (7 bytes of 0x55).
  - Then SFD 0xD5 as dibits 01,01,01,11.
- HEADER: 56 cycles carrying DST_MAC, SRC_MAC, ETHERTYPE.
  - s_ready=1 on the last HEADER cycle to accept the first payload byte.
  - If s_valid=0 on that cycle, treat it as underrun.
- PAYLOAD: 4 cycles per byte from an internal byte register.
  - s_ready=1 on the 4th dibit of each byte, unless the current byte carried s_last.
  - The 11-bit byte counter increments on each accept.
- Underrun: s_ready=1 with s_valid=0.
  - Pulse tx_err and drop txen the next cycle (frame truncated, no FCS).
  - Go to IFG.
- Oversize: MAX_PAYLOAD bytes accepted without s_last.
  - s_ready stays 0 for the rest of the frame.
  - After the last dibit of that byte: pulse tx_err, drop txen, go to IFG.
- End of payload, after the last dibit of the s_last byte:
  - if byte count < MIN_PAYLOAD, go to PAD and send (MIN_PAYLOAD - count) zero bytes;
  - otherwise go to FCS.
- CRC-32:
  - Polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF.
  - Updated 2 bits per cycle over DST_MAC through the pad.
- FCS: 16 cycles transmitting ~crc, bit 0 first. Then txen=0 and go to IFG.
- IFG: IFG_DIBITS cycles with txen=0 and txd=0, then IDLE. s_valid during IFG is ignored (no acceptance).
- txd is 2'b00 whenever txen=0.
- txen/txd are registered outputs; s_ready is combinational from state and counters.

Optional Feature:
- Macro: ETH_TX_FCS_EN.
- Defined:
  - CRC logic instantiated and the FCS state appends 4 bytes as above.
- Undefined:
  - No CRC logic; PAD/PAYLOAD exit directly to IFG.
  - txen drops immediately after the last payload/pad dibit.
  - The frame is 4 bytes shorter, for use with an external FCS appender.

Test Plan:
- 1-byte payload 0xA5 with s_last -> txen high exactly 288 cycles.
  - First 28 dibits 01, SFD 01,01,01,11.
  - Next 48 dibits 11 (broadcast DST_MAC).
  - Payload dibits 01,01,10,10, then 180 zero dibits, then 16 FCS dibits.
- Checker CRC over DST_MAC..FCS with the reflected register and no final xor -> residue 0xDEBB20E3.
- 60-byte payload -> no PAD cycles; txen high 32+56+240+16=344 cycles.
- Two frames back-to-back with s_valid held -> second txen rise exactly 48 cycles after first txen fall.
- s_valid deasserted at the 10th payload accept -> tx_err pulse, txen low next cycle, no FCS, IFG of 48, then a new frame is accepted.
- rst asserted mid-HEADER -> next cycle txen=0, busy=0, s_ready=0; a fresh frame starts cleanly with the preamble.
